// File: rtl/spi_master_n.sv
// spi_master_n: register-mapped SPI master with programmable mode, bit order,
// clock divider and NUM_SS active-low slave selects. One byte per transfer;
// the transfer starts on a DATA_OUT write and the result lands in DATA_IN.
module spi_master_n #(
  parameter int unsigned CLK_FREQ    = 48_000_000,
  parameter logic [7:0]  DEFAULT_DIV = 8'd23,
  parameter int unsigned NUM_SS      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_wr,
  input  logic [3:0]        i_addr,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_data,
  output logic              o_SCLK,
  output logic              o_MOSI,
  input  logic              i_MISO,
  output logic [NUM_SS-1:0] o_SS
);

  localparam logic [3:0] ADDR_STATUS   = 4'd0;
  localparam logic [3:0] ADDR_DATA_OUT = 4'd1;
  localparam logic [3:0] ADDR_DATA_IN  = 4'd2;
  localparam logic [3:0] ADDR_CTRL     = 4'd3;
  localparam logic [3:0] ADDR_SS_SEL   = 4'd4;
  localparam logic [3:0] ADDR_CLK_DIV  = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Reject unsupported configurations at elaboration time.
  if (NUM_SS < 1 || NUM_SS > 8 || CLK_FREQ == 0) begin : g_param_check
    $error("spi_master_n: NUM_SS must be 1..8 and CLK_FREQ nonzero");
  end

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;          // [0] cpha [1] cpol [2] ss_en [3] lsb_first
  logic [2:0]  ss_sel_q, ss_sel_d;
  logic [7:0]  clk_div_q, clk_div_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  din_q, din_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic        collision_q, collision_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  cnt_q, cnt_d;            // i_clk cycles within the current half-period
  logic [3:0]  edge_cnt_q, edge_cnt_d;  // SCLK edges already produced (0..15)
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic [7:0]  rdata_q, rdata_d;

  logic busy, wr_en, rd_en, cfg_addr, start, expiry, odd_edge, last_edge, din_rd;
  logic cpha, cpol, ss_en, lsb_first;

  assign cpha      = ctrl_q[0];
  assign cpol      = ctrl_q[1];
  assign ss_en     = ctrl_q[2];
  assign lsb_first = ctrl_q[3];

  assign busy      = (state_q != ST_IDLE);
  assign wr_en     = i_en & i_wr;
  assign rd_en     = i_en & ~i_wr;
  assign din_rd    = rd_en && (i_addr == ADDR_DATA_IN);
  assign cfg_addr  = (i_addr == ADDR_DATA_OUT) || (i_addr == ADDR_CTRL) ||
                     (i_addr == ADDR_SS_SEL)   || (i_addr == ADDR_CLK_DIV);
  assign start     = wr_en && (i_addr == ADDR_DATA_OUT) && (state_q == ST_IDLE);
  assign expiry    = (state_q == ST_SHIFT) && (cnt_q == clk_div_q);
  // Edge number about to be produced is edge_cnt_q+1, so it is odd when edge_cnt_q is even.
  assign odd_edge  = ~edge_cnt_q[0];
  assign last_edge = (edge_cnt_q == 4'd15);

  // State register and all datapath flops, synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      ss_sel_q    <= '0;
      clk_div_q   <= DEFAULT_DIV;
      dout_q      <= '0;
      din_q       <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      collision_q <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      edge_cnt_q  <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      ss_sel_q    <= ss_sel_d;
      clk_div_q   <= clk_div_d;
      dout_q      <= dout_d;
      din_q       <= din_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      collision_q <= collision_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic: IDLE -> SHIFT on a DATA_OUT write, SHIFT -> DONE after edge 16.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (expiry && last_edge) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Register file access, shift engine and end-of-transfer bookkeeping.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    ctrl_d      = ctrl_q;
    ss_sel_d    = ss_sel_q;
    clk_div_d   = clk_div_q;
    dout_d      = dout_q;
    din_d       = din_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    collision_d = collision_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    edge_cnt_d  = edge_cnt_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rdata_d     = rdata_q;

    // Writes: STATUS flags are write-one-to-clear; configuration is frozen while busy.
    if (wr_en) begin
      if (i_addr == ADDR_STATUS) begin
        if (i_data[2]) overrun_d   = 1'b0;
        if (i_data[3]) collision_d = 1'b0;
      end else if (cfg_addr) begin
        if (busy) begin
          collision_d = 1'b1;
        end else begin
          case (i_addr)
            ADDR_DATA_OUT: dout_d    = i_data;
            ADDR_CTRL:     ctrl_d    = i_data[3:0];
            ADDR_SS_SEL:   ss_sel_d  = i_data[2:0];
            ADDR_CLK_DIV:  clk_div_d = i_data;
            default:       ;
          endcase
        end
      end
    end

    // Reads: registered data, undefined addresses read as zero.
    if (rd_en) begin
      case (i_addr)
        ADDR_STATUS:   rdata_d = {4'b0, collision_q, overrun_q, rx_valid_q, busy};
        ADDR_DATA_OUT: rdata_d = dout_q;
        ADDR_DATA_IN:  rdata_d = din_q;
        ADDR_CTRL:     rdata_d = {4'b0, ctrl_q};
        ADDR_SS_SEL:   rdata_d = {5'b0, ss_sel_q};
        ADDR_CLK_DIV:  rdata_d = clk_div_q;
        default:       rdata_d = 8'h00;
      endcase
      if (din_rd) rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d      = '0;
          edge_cnt_d = '0;
          sclk_d     = cpol;
          rx_d       = '0;
          tx_d       = i_data;
          // CPHA=0 presents the first bit before the first SCLK edge.
          if (!cpha) begin
            mosi_d = lsb_first ? i_data[0] : i_data[7];
            tx_d   = lsb_first ? (i_data >> 1) : (i_data << 1);
          end
        end
      end
      ST_SHIFT: begin
        if (expiry) begin
          cnt_d      = '0;
          edge_cnt_d = edge_cnt_q + 4'd1;
          sclk_d     = ~sclk_q;
          // Sample on odd edges for CPHA=0 and even edges for CPHA=1; drive on the others.
          if (odd_edge != cpha) begin
            rx_d = lsb_first ? {i_MISO, rx_q[7:1]} : {rx_q[6:0], i_MISO};
          end else if (cpha || !last_edge) begin
            mosi_d = lsb_first ? tx_q[0] : tx_q[7];
            tx_d   = lsb_first ? (tx_q >> 1) : (tx_q << 1);
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        // A DATA_IN read this cycle returns the old byte and does not count as an overrun.
        din_d      = rx_q;
        rx_valid_d = 1'b1;
        if (rx_valid_q && !din_rd) overrun_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Pin outputs: SCLK parks at CPOL when idle, slave selects decode from the registers.
  always_comb begin
    o_SCLK = (state_q == ST_IDLE) ? cpol : sclk_q;
    o_SS   = '1;
    for (int k = 0; k < NUM_SS; k++) begin
      if (ss_en && (ss_sel_q == 3'(k))) o_SS[k] = 1'b0;
    end
  end

  assign o_MOSI = mosi_q;
  assign o_data = rdata_q;

endmodule

// File: tb/tb_spi_master_n.sv
// tb_spi_master_n: randomized register-level stimulus against a reference
// register model plus an SPI slave that follows the standard mode rules.
module tb_spi_master_n;

  localparam int NUM_SS = 4;

  logic       i_clk = 1'b0;
  logic       i_rst, i_en, i_wr;
  logic [3:0] i_addr;
  logic [7:0] i_data, o_data;
  logic       o_SCLK, o_MOSI;
  logic [NUM_SS-1:0] o_SS;
  logic       miso_r = 1'b0;

  spi_master_n #(.CLK_FREQ(48_000_000), .DEFAULT_DIV(8'd23), .NUM_SS(NUM_SS)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en),
    .i_wr  (i_wr),
    .i_addr(i_addr),
    .i_data(i_data),
    .o_data(o_data),
    .o_SCLK(o_SCLK),
    .o_MOSI(o_MOSI),
    .i_MISO(miso_r),
    .o_SS  (o_SS)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference register model.
  logic [3:0] exp_ctrl;
  logic [2:0] exp_ss;
  logic [7:0] exp_div, exp_dout, exp_din;
  logic       exp_rxv, exp_ovr, exp_col;

  task automatic model_reset();
    exp_ctrl = '0; exp_ss = '0; exp_div = 8'd23; exp_dout = '0; exp_din = '0;
    exp_rxv = 1'b0; exp_ovr = 1'b0; exp_col = 1'b0;
  endtask

  function automatic logic [7:0] model_rd(input logic [3:0] a);
    case (a)
      4'd0:    return {4'b0, exp_col, exp_ovr, exp_rxv, 1'b0};
      4'd1:    return exp_dout;
      4'd2:    return exp_din;
      4'd3:    return {4'b0, exp_ctrl};
      4'd4:    return {5'b0, exp_ss};
      4'd5:    return exp_div;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [NUM_SS-1:0] model_ss();
    logic [NUM_SS-1:0] v;
    v = '1;
    if (exp_ctrl[2] && int'(exp_ss) < NUM_SS) v[exp_ss] = 1'b0;
    return v;
  endfunction

  // SPI slave: configured by the main process, owned by the negedge monitor.
  logic       cfg_active = 1'b0, cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0;
  logic [7:0] cfg_tx = '0;
  int         arm_seq = 0;
  int         seen_seq = 0;
  int         slv_edges = 0, slv_nbits = 0, slv_idx = 0;
  int         slv_edge_cyc [17];
  logic [7:0] slv_rx = '0;
  logic       slv_prev = 1'b0;

  function automatic logic slave_bit(input int i);
    return cfg_lsb ? cfg_tx[i] : cfg_tx[7-i];
  endfunction

  // Samples MOSI on the mode's sampling edge, shifts MISO on the other edge.
  always @(negedge i_clk) begin
    if (arm_seq != seen_seq) begin
      seen_seq  = arm_seq;
      slv_edges = 0;
      slv_nbits = 0;
      slv_rx    = '0;
      if (!cfg_cpha) begin
        miso_r  = slave_bit(0);
        slv_idx = 1;
      end else begin
        slv_idx = 0;
      end
    end else if (cfg_active && o_SCLK !== slv_prev) begin
      slv_edges++;
      if (slv_edges <= 16) slv_edge_cyc[slv_edges] = cyc;
      if ((o_SCLK == 1'b1) == (cfg_cpol == cfg_cpha)) begin
        if (slv_nbits < 8) begin
          if (cfg_lsb) slv_rx[slv_nbits] = o_MOSI;
          else         slv_rx[7-slv_nbits] = o_MOSI;
          slv_nbits++;
        end
      end else if (slv_idx < 8) begin
        miso_r = slave_bit(slv_idx);
        slv_idx++;
      end
    end
    slv_prev = o_SCLK;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
    i_en = 1'b1; i_wr = 1'b1; i_addr = a; i_data = d;
    tick();
    i_en = 1'b0;
    case (a)
      4'd0: begin
        if (d[2]) exp_ovr = 1'b0;
        if (d[3]) exp_col = 1'b0;
      end
      4'd3: exp_ctrl = d[3:0];
      4'd4: exp_ss   = d[2:0];
      4'd5: exp_div  = d;
      default: ;
    endcase
  endtask

  task automatic reg_read(input string tag, input logic [3:0] a);
    logic [7:0] e;
    e = model_rd(a);
    i_en = 1'b1; i_wr = 1'b0; i_addr = a;
    tick();
    i_en = 1'b0;
    check(tag, o_data, e);
    if (a == 4'd2) exp_rxv = 1'b0;
  endtask

  // One full transfer. inject: mid-transfer DATA_OUT and CLK_DIV writes.
  // din_at_done: read DATA_IN in the DONE cycle.
  task automatic do_xfer(input logic [7:0] mbyte, input logic [7:0] sbyte,
                         input bit inject, input bit din_at_done);
    int half, busy_k, done_k, bad, start_cyc;
    logic [7:0] old_din;
    half   = int'(exp_div) + 1;
    done_k = 16 * half + 1;
    busy_k = -1;
    cfg_cpha = exp_ctrl[0]; cfg_cpol = exp_ctrl[1]; cfg_lsb = exp_ctrl[3];
    cfg_tx = sbyte; cfg_active = 1'b1; arm_seq++;
    tick();
    check("sclk_idle", o_SCLK, cfg_cpol);
    i_en = 1'b1; i_wr = 1'b1; i_addr = 4'd1; i_data = mbyte;
    tick();
    start_cyc = cyc;
    exp_dout  = mbyte;
    old_din   = exp_din;
    for (int k = 1; k < 16 * 256 + 40; k++) begin
      if (inject && k == 5) begin
        i_wr = 1'b1; i_addr = 4'd1; i_data = ~mbyte; exp_col = 1'b1;
        tick();
      end else if (inject && k == 6) begin
        i_wr = 1'b1; i_addr = 4'd5; i_data = 8'h77;
        tick();
      end else if (din_at_done && k == done_k) begin
        i_wr = 1'b0; i_addr = 4'd2;
        tick();
        check("din_at_done", o_data, old_din);
      end else begin
        i_wr = 1'b0; i_addr = 4'd0;
        tick();
        if (o_data[0] == 1'b0) begin
          busy_k = k;
          break;
        end
      end
    end
    i_en = 1'b0;
    check("busy_time", busy_k, 16 * half + 2);
    if (!din_at_done) exp_ovr = exp_ovr | exp_rxv;
    exp_rxv = 1'b1;
    exp_din = sbyte;
    check("sclk_edges", slv_edges, 16);
    check("mosi_byte", slv_rx, mbyte);
    bad = 0;
    for (int e = 1; e <= 16; e++)
      if (slv_edge_cyc[e] != start_cyc + e * half) bad++;
    check("sclk_timing", bad, 0);
    check("sclk_park", o_SCLK, cfg_cpol);
    check("mosi_hold", o_MOSI, cfg_lsb ? mbyte[7] : mbyte[0]);
    check("ss_during", o_SS, model_ss());
    cfg_active = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b, keep;
    logic [1:0] m;
    int waited;

    // Reset with a pending write strobe: reset wins.
    i_rst = 1'b1; i_en = 1'b1; i_wr = 1'b1; i_addr = 4'd1; i_data = 8'hFF;
    model_reset();
    repeat (3) tick();
    check("rst_sclk", o_SCLK, 1'b0);
    check("rst_mosi", o_MOSI, 1'b0);
    check("rst_ss", o_SS, 4'hF);
    check("rst_data", o_data, 8'h00);
    i_rst = 1'b0; i_en = 1'b0;
    tick();
    for (int r = 0; r < 6; r++) reg_read("rst_reg", 4'(r));
    reg_read("undef_rd", 4'hF);

    // CTRL upper bits are ignored; o_data holds between reads.
    reg_write(4'd3, 8'hF4);
    reg_read("ctrl_mask", 4'd3);
    keep = o_data;
    reg_write(4'd5, 8'd0);
    check("rdata_hold", o_data, keep);

    // Mode 0, maximum rate, SS line 1.
    reg_write(4'd3, 8'h04);
    reg_write(4'd4, 8'd1);
    check("ss_sel1", o_SS, 4'b1101);
    do_xfer(8'hA5, 8'h3C, 0, 0);
    reg_read("status_rx", 4'd0);
    reg_read("din_3c", 4'd2);
    reg_read("status_clr", 4'd0);

    // Modes 1..3, LSB first, half-period of 4 cycles.
    for (int md = 1; md <= 3; md++) begin
      reg_write(4'd3, 8'h0C | 8'(md));
      reg_write(4'd5, 8'd3);
      do_xfer(8'h81, 8'($urandom), 0, 0);
      reg_read("din_mode", 4'd2);
    end

    // Randomized transfers.
    for (int t = 0; t < 6; t++) begin
      m = 2'($urandom);
      reg_write(4'd3, {4'b0, 1'($urandom), 1'b1, m});
      reg_write(4'd5, 8'($urandom_range(0, 4)));
      reg_write(4'd4, 8'($urandom_range(0, 3)));
      do_xfer(8'($urandom), 8'($urandom), 0, 0);
      reg_read("din_rand", 4'd2);
      reg_read("status_rand", 4'd0);
    end

    // Overrun: two transfers without reading DATA_IN, then W1C.
    reg_write(4'd3, 8'h04);
    reg_write(4'd5, 8'd1);
    a = 8'($urandom); b = 8'($urandom);
    do_xfer(8'h11, a, 0, 0);
    do_xfer(8'h22, b, 0, 0);
    reg_read("status_ovr", 4'd0);
    reg_read("din_2nd", 4'd2);
    reg_write(4'd0, 8'h04);
    reg_read("status_w1c", 4'd0);

    // DATA_IN read in the DONE cycle: old byte, rx_valid stays, no overrun.
    do_xfer(8'h33, 8'h5E, 0, 0);
    do_xfer(8'h44, 8'hC7, 0, 1);
    reg_read("status_done_rd", 4'd0);
    reg_read("din_done_rd", 4'd2);

    // Collision: mid-transfer writes are dropped.
    reg_write(4'd5, 8'd2);
    do_xfer(8'h5A, 8'h96, 1, 0);
    reg_read("status_col", 4'd0);
    reg_read("div_kept", 4'd5);
    reg_read("dout_kept", 4'd1);
    reg_read("din_col", 4'd2);
    reg_write(4'd0, 8'h08);
    reg_read("status_col_clr", 4'd0);

    // Slave-select decode including out-of-range selects and disable.
    for (int s = 0; s < 8; s++) begin
      reg_write(4'd4, 8'(s));
      check("ss_decode", o_SS, model_ss());
    end
    reg_write(4'd4, 8'd5);
    check("ss_sel5", o_SS, 4'hF);
    reg_write(4'd3, 8'h00);
    reg_write(4'd4, 8'd2);
    check("ss_disabled", o_SS, 4'hF);

    // Reset in the middle of a transfer, at SCLK edge 7.
    reg_write(4'd3, 8'h04);
    reg_write(4'd5, 8'd3);
    cfg_cpha = 1'b0; cfg_cpol = 1'b0; cfg_lsb = 1'b0; cfg_tx = 8'hE1;
    cfg_active = 1'b1; arm_seq++;
    tick();
    i_en = 1'b1; i_wr = 1'b1; i_addr = 4'd1; i_data = 8'h6B;
    tick();
    i_en = 1'b0;
    waited = 0;
    while (slv_edges < 7 && waited < 500) begin
      tick();
      waited++;
    end
    check("edge7_reached", slv_edges, 7);
    cfg_active = 1'b0;
    i_rst = 1'b1;
    tick();
    check("abort_sclk", o_SCLK, 1'b0);
    check("abort_ss", o_SS, 4'hF);
    i_rst = 1'b0;
    model_reset();
    reg_read("abort_status", 4'd0);
    repeat (100) tick();
    reg_read("abort_status_late", 4'd0);
    reg_read("abort_din", 4'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
